debug_trace_buffer: RTL and testbench

//  Receiving end of MIPS_CPU debug outputs (pc/instruction/alu_result/mem_data).

---
 rtl/debug_trace_buffer.sv | 139 +++++++++++++
 tb/tb_debug_trace_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_buffer.sv
`default_nettype none
// ============================================================================
// debug_trace_buffer: PC-triggered circular capture of CPU debug records,
// drained oldest-first as 32-bit words over a valid/ready port.  Rev 1.0
// ============================================================================
module debug_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int POST_TRIG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   instr_in,
  input  logic [31:0]   alu_in,
  input  logic [31:0]   mem_in,
  input  logic          arm,
  input  logic          trig_en,
  input  logic [31:0]   trig_pc,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
  output logic          rd_last,
  output logic [1:0]    state_o,
  output logic [AW:0]   count_o,
  output logic          overflow
);

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PT   = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DUMP = 2'd3
  } state_t;

  state_t         state;
  logic [127:0]   mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    count;
  logic [AW:0]    count_inc;
  logic [AW-1:0]  post_cnt;
  logic [1:0]     word;
  logic [127:0]   rec;
  logic           wr;
  logic           hit;
  logic           to_dump;
  logic           xfer;

  assign wr        = (state == PRE || state == POST) && !arm;
  assign hit       = (state == PRE) && trig_en && (pc_in == trig_pc);
  assign to_dump   = wr && ((hit && POST_TRIG == 0) ||
                            (state == POST && post_cnt == AW'(1)));
  assign count_inc = (count == FULL) ? count : count + (AW+1)'(1);
  assign xfer      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {pc_in, instr_in, alu_in, mem_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      post_cnt <= '0;
      word     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= PRE;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        PRE, POST: begin
          if (arm) begin
            state    <= PRE;
            count    <= '0;
            overflow <= 1'b0;
          end else begin
            wp    <= wp + AW'(1);
            count <= count_inc;
            if (count == FULL) overflow <= 1'b1;
            if (state == POST) post_cnt <= post_cnt - AW'(1);
            // Oldest record sits count entries behind the post-write pointer.
            if (to_dump) begin
              state <= DUMP;
              rp    <= wp + AW'(1) - count_inc[AW-1:0];
              word  <= '0;
            end else if (hit) begin
              state    <= POST;
              post_cnt <= PT;
            end
          end
        end
        DUMP: begin
          if (xfer) begin
            if (word == 2'd3) begin
              word  <= '0;
              rp    <= rp + AW'(1);
              count <= count - (AW+1)'(1);
              if (count == (AW+1)'(1)) state <= IDLE;
            end else begin
              word <= word + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rec      = mem[rp];
  assign rd_valid = (state == DUMP);
  assign rd_last  = rd_valid && (count == (AW+1)'(1)) && (word == 2'd3);
  assign state_o  = state;
  assign count_o  = count;

  always_comb begin
    rd_data = '0;
    if (rd_valid) begin
      case (word)
        2'd0:    rd_data = rec[127:96];
        2'd1:    rd_data = rec[95:64];
        2'd2:    rd_data = rec[63:32];
        default: rd_data = rec[31:0];
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_debug_trace_buffer: scoreboard bench for debug_trace_buffer.  Rev 1.0
// ============================================================================
module tb_debug_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int P     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instr_in, alu_in, mem_in;
  logic        arm, trig_en;
  logic [31:0] trig_pc;
  logic        rd_valid, rd_ready, rd_last, overflow;
  logic [31:0] rd_data;
  logic [1:0]  state_o;
  logic [AW:0] count_o;

  always #5 clk = ~clk;

  debug_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST_TRIG(P)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .alu_in(alu_in), .mem_in(mem_in), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .state_o(state_o),
    .count_o(count_o), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] trig;
    int          exp_count;
    logic        exp_ovf;
    int          exp_words;
    logic [31:0] exp_first;
    int          stall_at;
  } vec_t;

  vec_t         vecs[5];
  logic [127:0] mq[$];
  logic [31:0]  wq[$];
  int           checks = 0;
  int           errors = 0;
  int           phase;
  int           last_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rec_of(input logic [31:0] pc);
    return {pc, pc ^ 32'hA5A5_0000, pc + 32'h1000_0001, ~pc};
  endfunction

  // Arms the buffer, feeds pc=0,4,8,... and models which records survive.
  task automatic run_capture(input logic [31:0] trig, input logic ten, input int maxc);
    logic [31:0] pcv  = 32'h0;
    int          left = 0;
    int          n    = 0;
    mq.delete();
    wq.delete();
    phase   = 1;
    trig_pc = trig;
    trig_en = ten;
    arm = 1'b1; tick; arm = 1'b0;
    while (phase != 3 && n < maxc) begin
      {pc_in, instr_in, alu_in, mem_in} = rec_of(pcv);
      tick;
      mq.push_back(rec_of(pcv));
      if (mq.size() > DEPTH) mq.delete(0);
      if (phase == 1 && ten && pcv == trig) begin
        if (P == 0) phase = 3;
        else begin phase = 2; left = P; end
      end else if (phase == 2) begin
        left--;
        if (left == 0) phase = 3;
      end
      pcv += 32'd4;
      n++;
    end
    if (phase == 3) begin
      foreach (mq[i]) begin
        wq.push_back(mq[i][127:96]);
        wq.push_back(mq[i][95:64]);
        wq.push_back(mq[i][63:32]);
        wq.push_back(mq[i][31:0]);
      end
    end
  endtask

  task automatic drain(input int stall_at, output int last_idx);
    int          n      = 0;
    int          budget = 0;
    logic [31:0] hd;
    logic        hl;
    logic [31:0] e;
    last_idx = -1;
    rd_ready = 1'b1;
    while (wq.size() > 0 && budget < 2000) begin
      budget++;
      if (rd_valid !== 1'b1) begin
        tick;
      end else begin
        if (n == stall_at) begin
          rd_ready = 1'b0;
          hd = rd_data;
          hl = rd_last;
          repeat (5) begin
            tick;
            check("hold_valid", {31'b0, rd_valid}, 32'd1);
            check("hold_data", rd_data, hd);
            check("hold_last", {31'b0, rd_last}, {31'b0, hl});
          end
          rd_ready = 1'b1;
        end
        e = wq.pop_front();
        check("rd_data", rd_data, e);
        check("rd_last", {31'b0, rd_last}, {31'b0, (wq.size() == 0)});
        if (rd_last === 1'b1) last_idx = n + 1;
        n++;
        tick;
      end
    end
    check("drain_left", wq.size(), 32'd0);
    check("after_valid", {31'b0, rd_valid}, 32'd0);
    check("after_state", {30'b0, state_o}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    pc_in = '0; instr_in = '0; alu_in = '0; mem_in = '0;

    vecs[0] = '{32'h40, 16, 1'b1, 64, 32'h24, -1};
    vecs[1] = '{32'h08, 11, 1'b0, 44, 32'h00, 20};
    vecs[2] = '{32'h00,  9, 1'b0, 36, 32'h00, -1};
    vecs[3] = '{32'h1C, 16, 1'b0, 64, 32'h00, 63};
    vecs[4] = '{32'h20, 16, 1'b1, 64, 32'h04,  0};

    repeat (2) tick;
    check("rst_state", {30'b0, state_o}, 32'd0);
    check("rst_count", {27'b0, count_o}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_last", {31'b0, rd_last}, 32'd0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 5; i++) begin
      run_capture(vecs[i].trig, 1'b1, 200);
      check("dump_state", {30'b0, state_o}, 32'd3);
      check("dump_count", {27'b0, count_o}, vecs[i].exp_count);
      check("dump_ovf", {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
      check("dump_valid", {31'b0, rd_valid}, 32'd1);
      check("first_word", rd_data, vecs[i].exp_first);
      drain(vecs[i].stall_at, last_at);
      check("last_index", last_at, vecs[i].exp_words);
    end

    // No trigger: stays in PRE with a full, overflowed buffer.
    run_capture(32'h0, 1'b0, 40);
    check("notrig_state", {30'b0, state_o}, 32'd1);
    check("notrig_count", {27'b0, count_o}, 32'd16);
    check("notrig_ovf", {31'b0, overflow}, 32'd1);
    check("notrig_valid", {31'b0, rd_valid}, 32'd0);

    // Re-arm while in POST, then a fresh trigger.
    run_capture(32'h8, 1'b1, 5);
    check("post_state", {30'b0, state_o}, 32'd2);
    arm = 1'b1; tick; arm = 1'b0;
    check("rearm_state", {30'b0, state_o}, 32'd1);
    check("rearm_count", {27'b0, count_o}, 32'd0);
    check("rearm_ovf", {31'b0, overflow}, 32'd0);
    run_capture(32'h10, 1'b1, 200);
    check("retrig_state", {30'b0, state_o}, 32'd3);
    check("retrig_count", {27'b0, count_o}, 32'd13);
    drain(-1, last_at);
    check("retrig_last", last_at, 32'd52);

    // Asynchronous reset in the middle of a drain.
    run_capture(32'h4, 1'b1, 200);
    check("mid_valid", {31'b0, rd_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, rd_valid}, 32'd0);
    check("arst_state", {30'b0, state_o}, 32'd0);
    check("arst_count", {27'b0, count_o}, 32'd0);
    check("arst_data", rd_data, 32'd0);
    #1 reset = 1'b0;
    tick;
    check("arst_idle", {30'b0, state_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
